// File: rtl/seq_add_unit_pkg.sv
// rtl/seq_add_unit_pkg.sv - op and FSM state encodings shared by the sequential adder
package seq_add_unit_pkg;

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_ADC = 2'b10;
    localparam logic [1:0] OP_SBC = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_RUN  = 2'b01,
        S_DONE = 2'b10
    } state_t;

endpackage

// File: rtl/add_slice.sv
// rtl/add_slice.sv - combinational W-bit adder slice with carry in/out
module add_slice #(
    parameter int W = 4
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         ci,
    output logic [W-1:0] s,
    output logic         co
);

    assign {co, s} = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, ci};

endmodule

// File: rtl/seq_add_unit.sv
// rtl/seq_add_unit.sv - multi-cycle slice-serial add/sub unit with N/Z/C/V flags
module seq_add_unit
    import seq_add_unit_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int SLICE = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             carry,
    output logic             overflow,
    output logic             zero,
    output logic             negative
);

    localparam int NSLICE = WIDTH / SLICE;
    localparam int CW     = (NSLICE > 1) ? $clog2(NSLICE) : 1;
    localparam logic [CW-1:0] LAST = CW'(NSLICE - 1);

    state_t           state, state_next;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] a_q, b_q;
    logic             run_c;

    logic [WIDTH-1:0] b_eff;
    logic             c0;
    logic [SLICE-1:0] a_sl, b_sl, s_sl;
    logic             c_out;
    logic [WIDTH-1:0] sum_next;
    logic             accept;

    always_comb begin
        b_eff = op[0] ? ~b : b;
        case (op)
            OP_ADD:  c0 = 1'b0;
            OP_SUB:  c0 = 1'b1;
            OP_ADC:  c0 = cin;
            default: c0 = cin;
        endcase
    end

    assign accept = start && (state == S_IDLE || state == S_DONE);

    assign a_sl = a_q[cnt*SLICE +: SLICE];
    assign b_sl = b_q[cnt*SLICE +: SLICE];

    add_slice #(.W(SLICE)) u_slice (
        .a  (a_sl),
        .b  (b_sl),
        .ci (run_c),
        .s  (s_sl),
        .co (c_out)
    );

    // Full result as it will look after this edge, so completion flags see the last slice.
    always_comb begin
        sum_next = sum;
        sum_next[cnt*SLICE +: SLICE] = s_sl;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:  if (start) state_next = S_RUN;
            S_RUN:   if (cnt == LAST) state_next = S_DONE;
            S_DONE:  state_next = start ? S_RUN : S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt      <= '0;
            a_q      <= '0;
            b_q      <= '0;
            run_c    <= 1'b0;
            sum      <= '0;
            carry    <= 1'b0;
            overflow <= 1'b0;
            zero     <= 1'b0;
            negative <= 1'b0;
        end else if (accept) begin
            cnt   <= '0;
            a_q   <= a;
            b_q   <= b_eff;
            run_c <= c0;
            sum   <= '0;
        end else if (state == S_RUN) begin
            sum   <= sum_next;
            run_c <= c_out;
            if (cnt == LAST) begin
                carry    <= c_out;
                overflow <= (a_q[WIDTH-1] == b_q[WIDTH-1]) && (sum_next[WIDTH-1] != a_q[WIDTH-1]);
                zero     <= (sum_next == '0);
                negative <= sum_next[WIDTH-1];
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

    assign busy = (state == S_RUN);
    assign done = (state == S_DONE);

endmodule

// File: tb/tb_seq_add_unit.sv
// tb/tb_seq_add_unit.sv - directed self-checking bench for seq_add_unit
module tb_seq_add_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b1;

    logic        start = 1'b0;
    logic [1:0]  op = 2'b00;
    logic [15:0] a = '0, b = '0;
    logic        cin = 1'b0;
    logic        busy, done, carry, overflow, zero, negative;
    logic [15:0] sum;

    logic        start32 = 1'b0;
    logic [1:0]  op32 = 2'b00;
    logic [31:0] a32 = '0, b32 = '0;
    logic        busy32, done32, carry32, overflow32, zero32, negative32;
    logic [31:0] sum32;

    logic        start8 = 1'b0;
    logic [1:0]  op8 = 2'b00;
    logic [7:0]  a8 = '0, b8 = '0;
    logic        busy8, done8, carry8, overflow8, zero8, negative8;
    logic [7:0]  sum8;

    int checks = 0;
    int errors = 0;
    int lat, nb;

    always #5 clk = ~clk;

    seq_add_unit dut (
        .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b), .cin(cin),
        .busy(busy), .done(done), .sum(sum), .carry(carry),
        .overflow(overflow), .zero(zero), .negative(negative)
    );

    seq_add_unit #(.WIDTH(32), .SLICE(8)) dut32 (
        .clk(clk), .rst(rst), .start(start32), .op(op32), .a(a32), .b(b32), .cin(1'b0),
        .busy(busy32), .done(done32), .sum(sum32), .carry(carry32),
        .overflow(overflow32), .zero(zero32), .negative(negative32)
    );

    seq_add_unit #(.WIDTH(8), .SLICE(8)) dut8 (
        .clk(clk), .rst(rst), .start(start8), .op(op8), .a(a8), .b(b8), .cin(1'b0),
        .busy(busy8), .done(done8), .sum(sum8), .carry(carry8),
        .overflow(overflow8), .zero(zero8), .negative(negative8)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic wait_done(output int n, output int nbusy);
        n = 0;
        nbusy = 0;
        while (!done && n < 20) begin
            if (busy) nbusy++;
            @(posedge clk); #1;
            n++;
        end
    endtask

    task automatic issue(input logic [1:0] o, input logic [15:0] x, input logic [15:0] y, input logic ci);
        @(posedge clk); #1;
        op = o; a = x; b = y; cin = ci; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        op = ~o; a = ~x; b = 16'h5A5A; cin = ~ci;
    endtask

    task automatic run_vec(input string tag, input logic [1:0] o, input logic [15:0] x,
                           input logic [15:0] y, input logic ci, input logic [15:0] es,
                           input logic ec, input logic ev, input logic ez, input logic en);
        issue(o, x, y, ci);
        wait_done(lat, nb);
        check({tag, " latency"}, lat, 4);
        check({tag, " sum"}, sum, es);
        check({tag, " flags CVZN"}, {carry, overflow, zero, negative}, {ec, ev, ez, en});
        @(posedge clk); #1;
        check({tag, " done pulse"}, {done, busy}, 2'b00);
    endtask

    initial begin
        #12;
        check("reset outputs", {busy, done, carry, overflow, zero, negative}, 6'b0);
        check("reset sum", sum, 16'h0000);
        @(negedge clk);
        rst = 1'b0;

        issue(2'b00, 16'h0002, 16'h0004, 1'b0);
        wait_done(lat, nb);
        check("add small latency", lat, 4);
        check("add small busy cycles", nb, 4);
        check("add small sum", sum, 16'h0006);
        check("add small flags CVZN", {carry, overflow, zero, negative}, 4'b0000);
        @(posedge clk); #1;
        check("add small done pulse", done, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        check("hold in idle", sum, 16'h0006);

        run_vec("add pos ovf",  2'b00, 16'h4000, 16'h4000, 1'b0, 16'h8000, 1'b0, 1'b1, 1'b0, 1'b1);
        run_vec("add wrap",     2'b00, 16'hC000, 16'h4000, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1, 1'b0);
        run_vec("add neg ovf",  2'b00, 16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b1, 1'b0);
        run_vec("sub borrow",   2'b01, 16'h0005, 16'h0007, 1'b0, 16'hFFFE, 1'b0, 1'b0, 1'b0, 1'b1);
        run_vec("sub noborrow", 2'b01, 16'h0007, 16'h0005, 1'b1, 16'h0002, 1'b1, 1'b0, 1'b0, 1'b0);
        run_vec("adc cin",      2'b10, 16'hFFFF, 16'h0000, 1'b1, 16'h0000, 1'b1, 1'b0, 1'b1, 1'b0);
        run_vec("sbc cin",      2'b11, 16'h0005, 16'h0003, 1'b1, 16'h0002, 1'b1, 1'b0, 1'b0, 1'b0);
        run_vec("add cin ign",  2'b00, 16'h0001, 16'h0001, 1'b1, 16'h0002, 1'b0, 1'b0, 1'b0, 1'b0);
        run_vec("sbc no cin",   2'b11, 16'h0005, 16'h0003, 1'b0, 16'h0001, 1'b1, 1'b0, 1'b0, 1'b0);

        // start during RUN must be ignored
        @(posedge clk); #1;
        op = 2'b00; a = 16'h1111; b = 16'h2222; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        op = 2'b01; a = 16'hFFFF; b = 16'h0001; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        wait_done(lat, nb);
        check("ignore start latency", lat, 2);
        check("ignore start sum", sum, 16'h3333);

        // back-to-back: start held in DONE
        op = 2'b00; a = 16'h0001; b = 16'h0002; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        check("b2b busy", {busy, done}, 2'b10);
        wait_done(lat, nb);
        check("b2b latency", lat, 4);
        check("b2b sum", sum, 16'h0003);

        // reset mid-operation
        issue(2'b00, 16'h8234, 16'h9111, 1'b0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("abort pre busy", busy, 1'b1);
        rst = 1'b1;
        #1;
        check("abort outputs", {busy, done, carry, overflow, zero, negative}, 6'b0);
        check("abort sum", sum, 16'h0000);
        @(negedge clk);
        rst = 1'b0;
        nb = 0;
        repeat (6) begin
            @(posedge clk); #1;
            if (done || busy) nb++;
        end
        check("abort no done", nb, 0);
        run_vec("after abort", 2'b00, 16'h00FF, 16'h0001, 1'b0, 16'h0100, 1'b0, 1'b0, 1'b0, 1'b0);

        // WIDTH=32, SLICE=8
        @(posedge clk); #1;
        op32 = 2'b00; a32 = 32'h7FFF_FFFF; b32 = 32'h0000_0001; start32 = 1'b1;
        @(posedge clk); #1;
        start32 = 1'b0;
        lat = 0;
        while (!done32 && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        check("w32 latency", lat, 4);
        check("w32 sum", sum32, 32'h8000_0000);
        check("w32 flags CVZN", {carry32, overflow32, zero32, negative32}, 4'b0101);

        // WIDTH=8, SLICE=8: single slice
        @(posedge clk); #1;
        op8 = 2'b00; a8 = 8'h7F; b8 = 8'h01; start8 = 1'b1;
        @(posedge clk); #1;
        start8 = 1'b0;
        check("w8 busy", busy8, 1'b1);
        lat = 0;
        while (!done8 && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        check("w8 latency", lat, 1);
        check("w8 sum", sum8, 8'h80);
        check("w8 flags CVZN", {carry8, overflow8, zero8, negative8}, 4'b0101);

        @(posedge clk); #1;
        op8 = 2'b01; a8 = 8'h00; b8 = 8'h01; start8 = 1'b1;
        @(posedge clk); #1;
        start8 = 1'b0;
        lat = 0;
        while (!done8 && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        check("w8 sub latency", lat, 1);
        check("w8 sub sum", sum8, 8'hFF);
        check("w8 sub flags CVZN", {carry8, overflow8, zero8, negative8}, 4'b0001);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
